packet_sum_accumulator: RTL
===========================

// Module: packet_sum_accumulator
// PURPOSE
//  Downstream stage of the packet adder: consumes its per-beat sum stream (valid/ready/last).
//  Accumulates every beat of a packet and emits one record per packet: total, beat count, overflow flag.
//  Single output register; streaming throughput of one packet result per cycle when unstalled.
// PARAMETERS
//  WIDTH  8   operand width of the upstream adder; in_sum is WIDTH+1 bits
//  ACC_W  16  accumulator / out_total width (must be >= WIDTH+1)
//  CNT_W  8   beat-counter / out_count width
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst        in   1        asynchronous reset, active-high
//  in_sum     in   WIDTH+1  per-beat sum from packet adder
//  in_valid   in   1        in_sum/in_last valid
//  in_ready   out  1        stage can accept a beat
//  in_last    in   1        beat is last of packet
//  out_total  out  ACC_W    packet total
//  out_count  out  CNT_W    beats in packet
//  out_ovf    out  1        accumulator or counter overflowed in this packet
//  out_valid  out  1        result record valid
//  out_ready  in   1        consumer accepts record
// BEHAVIOUR
//  - Reset (async assert, sync release): out_total=0, out_count=0, out_ovf=0, out_valid=0; acc=0, cnt=0, ovf=0, state IDLE.
//  - Reset mid-packet discards the partial packet; no record emitted.
//  - in_ready = !out_valid | out_ready (combinational); accept = in_valid & in_ready.
//  - States: IDLE (no beats held) -> ACCUM on accepted non-last beat; ACCUM stays on non-last beat;
//    IDLE/ACCUM -> IDLE on accepted last beat (record loaded). Output-pending tracked by out_valid alone.
//  - Accepted beat: sum = (IDLE ? 0 : acc) + zero-extended in_sum, computed ACC_W+1 wide; carry sets ovf.
//    cnt_next = (IDLE ? 1 : cnt+1); saturates at 2^CNT_W-1 and sets ovf on attempted wrap.
//  - Non-last beat: acc <= sum[ACC_W-1:0] (or saturated, see CONFIGURATION), cnt <= cnt_next.
//  - Last beat: out_total <= acc result, out_count <= cnt_next, out_ovf <= ovf_next, out_valid <= 1;
//    acc, cnt, ovf cleared. Latency: record visible the cycle after the last beat is accepted.
//  - Single-beat packet (in_last on first beat): total = in_sum, count = 1.
//  - ovf is sticky within a packet, cleared at packet end.
//  - out_valid & out_ready & no last accept that cycle: out_valid <= 0, data regs hold old value.
//  - Simultaneous record handshake and last-beat accept: registers reload, out_valid stays 1.
//  - out_valid & !out_ready: out_* held stable; in_ready=0, upstream stalls.
//  - in_valid without in_ready: no state change; in_sum may change freely.
// CONFIGURATION
//  PKT_SAT_EN defined: on accumulator carry, acc/out_total clamp to 2^ACC_W-1 and stay there for the
//    rest of the packet; out_ovf=1.
//  PKT_SAT_EN undefined: accumulator wraps modulo 2^ACC_W; out_ovf=1 still reported.
//  Counter saturation and all handshake behaviour identical in both builds.
// TESTING
//  1. out_ready=1; beats 10,20,30 (last on 30) -> next cycle out_total=60, out_count=3, out_ovf=0, out_valid 1 cycle.
//  2. Single beat in_sum=511, in_last=1 -> out_total=511, out_count=1, out_ovf=0.
//  3. out_ready=0 with record pending; offer next packet 5,6 -> in_ready=0, outputs stable;
//     raise out_ready -> record consumed, then beats accepted, second record total=11, count=2.
//  4. ACC_W=10: beats 510,510,510 last -> wrap build out_total=506, ovf=1; PKT_SAT_EN build out_total=1023, ovf=1;
//     next packet 1 last -> total=1, ovf=0.
//  5. Beats 7,8 then rst pulse mid-packet -> all outputs 0, no record; then beat 5 last -> total=5, count=1.
//  6. out_ready=1; back-to-back single-beat packets 1,2,3 on consecutive cycles -> in_ready stays 1,
//     records 1,2,3 on three consecutive cycles; CNT_W=2 with 5-beat packet -> out_count=3, out_ovf=1.

Source files
------------

// File: rtl/packet_sum_accumulator_if.sv
// Beat-in / record-out handshake bundle for packet_sum_accumulator.
// master drives beats and out_ready; slave is the accumulator.
interface packet_sum_accumulator_if #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 16,
   parameter int CNT_W = 8
) ();
   logic [WIDTH:0]   in_sum;
   logic             in_valid;
   logic             in_ready;
   logic             in_last;
   logic [ACC_W-1:0] out_total;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in_sum, in_valid, in_last, out_ready,
      input  in_ready, out_total, out_count, out_ovf, out_valid
   );

   modport slave (
      input  in_sum, in_valid, in_last, out_ready,
      output in_ready, out_total, out_count, out_ovf, out_valid
   );
endinterface

// File: rtl/packet_sum_accumulator.sv
// packet_sum_accumulator: sums every beat of a packet, emits {total, count, ovf} one cycle after the last beat.
// in_ready = !out_valid | out_ready; optional PKT_SAT_EN clamps the accumulator instead of wrapping.
module packet_sum_accumulator #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 16,
   parameter int CNT_W = 8
) (
   input logic                    clk,
   input logic                    rst,
   packet_sum_accumulator_if.slave bus
);
   typedef enum logic {IDLE, ACCUM} state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W-1:0] out_total_q, out_total_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             out_ovf_q, out_ovf_d;
   logic             out_valid_q, out_valid_d;

   logic             in_ready;
   logic             accept;
   logic             first_beat;
   logic [ACC_W-1:0] acc_base;
   logic [ACC_W:0]   sum_w;
   logic [ACC_W-1:0] acc_res;
   logic [CNT_W-1:0] cnt_base, cnt_next;
   logic             cnt_wrap, ovf_next;

   assign in_ready      = !out_valid_q || bus.out_ready;
   assign accept        = bus.in_valid && in_ready;
   assign bus.in_ready  = in_ready;
   assign bus.out_total = out_total_q;
   assign bus.out_count = out_count_q;
   assign bus.out_ovf   = out_ovf_q;
   assign bus.out_valid = out_valid_q;

   always_comb begin
      first_beat = (state_q == IDLE);
      acc_base   = first_beat ? '0 : acc_q;
      sum_w      = {1'b0, acc_base} + {{(ACC_W - WIDTH){1'b0}}, bus.in_sum};
`ifdef PKT_SAT_EN
      // Once clamped, any further non-zero beat carries again, so the max value sticks.
      acc_res    = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
`else
      acc_res    = sum_w[ACC_W-1:0];
`endif
      cnt_base   = first_beat ? '0 : cnt_q;
      cnt_wrap   = &cnt_base;
      cnt_next   = cnt_wrap ? cnt_base : cnt_base + CNT_W'(1);
      ovf_next   = (!first_beat && ovf_q) || sum_w[ACC_W] || cnt_wrap;
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_total_d = out_total_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;
      out_valid_d = out_valid_q;

      if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (bus.in_last) begin
            out_total_d = acc_res;
            out_count_d = cnt_next;
            out_ovf_d   = ovf_next;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = IDLE;
         end else begin
            acc_d   = acc_res;
            cnt_d   = cnt_next;
            ovf_d   = ovf_next;
            state_d = ACCUM;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_total_q <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_total_q <= out_total_d;
         out_count_q <= out_count_d;
         out_ovf_q   <= out_ovf_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule
